// File: rtl/video_timing_gen_if.sv
// video_timing_gen_if: raster timing bundle from the generator to video consumers
// master drives the timing, slave observes it
interface video_timing_gen_if #(
   parameter int HCNT_WIDTH = 9,
   parameter int VCNT_WIDTH = 9
);
   logic                  pe;
   logic                  hs;
   logic                  vs;
   logic                  hb;
   logic                  vb;
   logic [HCNT_WIDTH-1:0] hcnt;
   logic [VCNT_WIDTH-1:0] vcnt;
   logic                  field;

   modport master (
      output pe, hs, vs, hb, vb, hcnt, vcnt, field
   );

   modport slave (
      input pe, hs, vs, hb, vb, hcnt, vcnt, field
   );
endinterface

// File: rtl/video_timing_gen.sv
// video_timing_gen: native-rate raster timing (hs/vs low, hb/vb high, 1-clk pe)
// Optional build macro VTG_INTERLACE_EN: alternating V_TOTAL / V_TOTAL+1 fields
module video_timing_gen #(
   parameter int HCNT_WIDTH = 9,
   parameter int VCNT_WIDTH = 9,
   parameter int H_ACTIVE   = 320,
   parameter int H_FP       = 16,
   parameter int H_SYNC     = 32,
   parameter int H_BP       = 32,
   parameter int V_ACTIVE   = 240,
   parameter int V_FP       = 3,
   parameter int V_SYNC     = 3,
   parameter int V_BP       = 16
) (
   input  logic               clk_sys,
   input  logic               reset_n,
   input  logic [3:0]         ce_divider,
   video_timing_gen_if.master vid
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [HCNT_WIDTH-1:0] A_END = HCNT_WIDTH'(H_ACTIVE - 1);
   localparam logic [HCNT_WIDTH-1:0] F_END = HCNT_WIDTH'(H_ACTIVE + H_FP - 1);
   localparam logic [HCNT_WIDTH-1:0] S_END =
      HCNT_WIDTH'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [HCNT_WIDTH-1:0] T_END = HCNT_WIDTH'(H_TOTAL - 1);

   localparam logic [VCNT_WIDTH-1:0] VS_ON  = VCNT_WIDTH'(V_ACTIVE + V_FP);
   localparam logic [VCNT_WIDTH-1:0] VS_OFF =
      VCNT_WIDTH'((V_ACTIVE + V_FP + V_SYNC) % V_TOTAL);
   localparam logic [VCNT_WIDTH-1:0] V_LAST = VCNT_WIDTH'(V_TOTAL - 1);
   localparam logic [VCNT_WIDTH-1:0] V_VIS  = VCNT_WIDTH'(V_ACTIVE);

   localparam bit FP_ZERO = (H_FP == 0);
   localparam bit BP_ZERO = (H_BP == 0);

   typedef enum logic [1:0] {
      ST_ACTIVE,
      ST_FP,
      ST_SYNC,
      ST_BP
   } hstate_t;

   hstate_t               hstate;
   logic [3:0]            div;
   logic [3:0]            limit;
   logic [3:0]            ce_lim;
   logic                  pe_q;
   logic                  hs_q;
   logic                  vs_q;
   logic                  hb_q;
   logic                  vb_q;
   logic [HCNT_WIDTH-1:0] hcnt;
   logic [VCNT_WIDTH-1:0] vcnt;
   logic [VCNT_WIDTH-1:0] v_last;
   logic [VCNT_WIDTH-1:0] vcnt_nxt;
   logic                  hs_fall;
   logic                  line_end;

   assign ce_lim = (ce_divider == 4'd0) ? 4'd3 : ce_divider;

`ifdef VTG_INTERLACE_EN
   localparam logic [HCNT_WIDTH-1:0] HALF =
      HCNT_WIDTH'((H_ACTIVE + H_FP - 1 + H_TOTAL / 2) % H_TOTAL);

   logic field_q;
   logic vs_pf;
   logic vs_pr;

   assign v_last = field_q ? V_LAST + 1'b1 : V_LAST;
`else
   assign v_last = V_LAST;
`endif

   assign vcnt_nxt = (vcnt == v_last) ? '0 : vcnt + 1'b1;

   // Decode the pixel on which hsync falls and the last pixel of the line
   always_comb begin
      hs_fall  = 1'b0;
      line_end = 1'b0;
      unique case (hstate)
         ST_ACTIVE: hs_fall  = FP_ZERO && (hcnt == A_END);
         ST_FP:     hs_fall  = (hcnt == F_END);
         ST_SYNC:   line_end = BP_ZERO && (hcnt == S_END);
         ST_BP:     line_end = (hcnt == T_END);
         default:   ;
      endcase
   end

   // Pixel divider, horizontal FSM, line counter and registered sync outputs
   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         div    <= '0;
         limit  <= ce_lim;
         pe_q   <= 1'b0;
         hstate <= ST_ACTIVE;
         hcnt   <= '0;
         vcnt   <= '0;
         hs_q   <= 1'b1;
         vs_q   <= 1'b1;
         hb_q   <= 1'b0;
         vb_q   <= 1'b0;
`ifdef VTG_INTERLACE_EN
         field_q <= 1'b0;
         vs_pf   <= 1'b0;
         vs_pr   <= 1'b0;
`endif
      end else begin
         pe_q <= (div == limit);
         div  <= (div == limit) ? '0 : div + 1'b1;
         if (pe_q) begin
            hcnt <= line_end ? '0 : hcnt + 1'b1;
            unique case (hstate)
               ST_ACTIVE: if (hcnt == A_END) begin
                  hb_q   <= 1'b1;
                  hstate <= FP_ZERO ? ST_SYNC : ST_FP;
               end
               ST_FP: if (hcnt == F_END) hstate <= ST_SYNC;
               ST_SYNC: if (hcnt == S_END) begin
                  hs_q   <= 1'b1;
                  hstate <= BP_ZERO ? ST_ACTIVE : ST_BP;
               end
               ST_BP: if (hcnt == T_END) hstate <= ST_ACTIVE;
               default: hstate <= ST_ACTIVE;
            endcase
            // Pixel width may only change at the hsync edge
            if (hs_fall) begin
               hs_q  <= 1'b0;
               limit <= ce_lim;
            end
            if (line_end) begin
               hb_q <= 1'b0;
               vcnt <= vcnt_nxt;
               vb_q <= (vcnt_nxt >= V_VIS);
            end
`ifdef VTG_INTERLACE_EN
            // Field 1 defers both vs edges by half a line
            if (hs_fall && vcnt == VS_ON) begin
               if (field_q) vs_pf <= 1'b1;
               else vs_q <= 1'b0;
            end
            if (hs_fall && vcnt == VS_OFF) begin
               if (field_q) vs_pr <= 1'b1;
               else vs_q <= 1'b1;
            end
            if (hcnt == HALF && vs_pf) begin
               vs_q  <= 1'b0;
               vs_pf <= 1'b0;
            end
            if (hcnt == HALF && vs_pr) begin
               vs_q  <= 1'b1;
               vs_pr <= 1'b0;
            end
            if (line_end && vcnt == v_last) field_q <= ~field_q;
`else
            if (hs_fall && vcnt == VS_ON) vs_q <= 1'b0;
            else if (hs_fall && vcnt == VS_OFF) vs_q <= 1'b1;
`endif
         end
      end
   end

   // Geometry sanity check, simulation only
   always @(posedge clk_sys) begin
      assert (H_SYNC >= 1 && V_SYNC >= 1 && H_ACTIVE >= 1 && V_ACTIVE >= 1)
         else $error("video_timing_gen: illegal raster geometry");
   end

   assign vid.pe   = pe_q;
   assign vid.hs   = hs_q;
   assign vid.vs   = vs_q;
   assign vid.hb   = hb_q;
   assign vid.vb   = vb_q;
   assign vid.hcnt = hcnt;
   assign vid.vcnt = vcnt;
`ifdef VTG_INTERLACE_EN
   assign vid.field = field_q;
`else
   assign vid.field = 1'b0;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: directed vectors for the raster timing generator
// main instance uses default geometry, small instance has zero porches
module tb_video_timing_gen;

   logic       clk_sys = 1'b0;
   logic       reset_n = 1'b0;
   logic [3:0] ce_divider = 4'd0;
   logic       rs_n = 1'b0;
   logic [3:0] ce_s = 4'd0;

   int checks = 0;
   int errors = 0;

   always #5 clk_sys = ~clk_sys;

   video_timing_gen_if #(.HCNT_WIDTH(9), .VCNT_WIDTH(9)) vm ();
   video_timing_gen_if #(.HCNT_WIDTH(4), .VCNT_WIDTH(4)) vsm ();

   video_timing_gen dut (
      .clk_sys    (clk_sys),
      .reset_n    (reset_n),
      .ce_divider (ce_divider),
      .vid        (vm)
   );

   video_timing_gen #(
      .HCNT_WIDTH (4),
      .VCNT_WIDTH (4),
      .H_ACTIVE   (8),
      .H_FP       (0),
      .H_SYNC     (4),
      .H_BP       (0),
      .V_ACTIVE   (6),
      .V_FP       (2),
      .V_SYNC     (3),
      .V_BP       (2)
   ) dut_s (
      .clk_sys    (clk_sys),
      .reset_n    (rs_n),
      .ce_divider (ce_s),
      .vid        (vsm)
   );

   typedef struct {
      logic [3:0] ce;
      int         first;
      int         per;
      int         hs_low;
      int         line;
      int         hb_hi;
   } vec_t;

   vec_t vt[4];

   task automatic chk(input string nm, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
      end
   endtask

   function automatic logic mon(input int s);
      case (s)
         0: return vm.pe;
         1: return vm.hs;
         2: return vm.hb;
         3: return vm.vs;
         default: return vm.vb;
      endcase
   endfunction

   task automatic wait_for(input int s, input logic v, input int budget,
                           output int n);
      n = 0;
      do begin
         @(negedge clk_sys);
         n++;
      end while (mon(s) !== v && n < budget);
      if (mon(s) !== v) begin
         checks++;
         errors++;
         $display("FAIL wait_sig%0d got=%b exp=%b after %0d clks",
                  s, mon(s), v, n);
         n = -1;
      end
   endtask

   int n, n1, n2, hl;
   int falls, rise_falls, rise_at, vb_err, vc_err, expv, prev_vc;
   bit wrap, done, rise_ok, ph, pv;

   initial begin
      vt[0] = '{4'd0, 4, 4, 128, 1600, 320};
      vt[1] = '{4'd5, 6, 6, 192, 2400, 480};
      vt[2] = '{4'd2, 3, 3, 96, 1200, 240};
      vt[3] = '{4'd1, 2, 2, 64, 800, 160};

      // table: reset, first pe, pe period, hs width, line period, hblank
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_sys);
         ce_divider = vt[i].ce;
         reset_n = 1'b0;
         @(negedge clk_sys);
         @(negedge clk_sys);
         chk("rst_flags", int'({vm.pe, vm.hs, vm.vs, vm.hb, vm.vb, vm.field}),
             int'(6'b011000));
         chk("rst_hcnt", int'(vm.hcnt), 0);
         chk("rst_vcnt", int'(vm.vcnt), 0);
         reset_n = 1'b1;
         wait_for(0, 1'b1, 100, n);
         chk("first_pe", n, vt[i].first);
         wait_for(0, 1'b0, 100, n1);
         wait_for(0, 1'b1, 100, n2);
         chk("pe_period", n1 + n2, vt[i].per);
         wait_for(1, 1'b0, 5000, n);
         wait_for(1, 1'b1, 5000, hl);
         chk("hs_low", hl, vt[i].hs_low);
         wait_for(1, 1'b0, 5000, n);
         chk("line_period", hl + n, vt[i].line);
         wait_for(2, 1'b0, 5000, n);
         wait_for(2, 1'b1, 5000, n);
         wait_for(2, 1'b0, 5000, n);
         chk("hb_high", n, vt[i].hb_hi);
      end

      // divider change mid-line applies from the hsync fall
      @(negedge clk_sys);
      ce_divider = 4'd5;
      reset_n = 1'b0;
      @(negedge clk_sys);
      reset_n = 1'b1;
      n = 0;
      while (vm.hcnt != 9'd100 && n < 5000) begin
         @(negedge clk_sys);
         n++;
      end
      chk("chg_reach", int'(vm.hcnt), 100);
      ce_divider = 4'd1;
      wait_for(0, 1'b1, 100, n);
      wait_for(0, 1'b0, 100, n1);
      wait_for(0, 1'b1, 100, n2);
      chk("chg_pe_before", n1 + n2, 6);
      wait_for(1, 1'b0, 5000, n);
      wait_for(1, 1'b1, 5000, hl);
      chk("chg_hs_low", hl, 64);
      wait_for(1, 1'b0, 5000, n);
      chk("chg_line", hl + n, 800);
      wait_for(0, 1'b1, 100, n);
      wait_for(0, 1'b0, 100, n1);
      wait_for(0, 1'b1, 100, n2);
      chk("chg_pe_after", n1 + n2, 2);

      // one-clock reset in the middle of a line
      @(negedge clk_sys);
      ce_divider = 4'd0;
      reset_n = 1'b0;
      @(negedge clk_sys);
      reset_n = 1'b1;
      n = 0;
      while (!(vm.hcnt == 9'd200 && vm.vcnt == 9'd2) && n < 10000) begin
         @(negedge clk_sys);
         n++;
      end
      chk("mid_reach", int'(vm.hcnt), 200);
      reset_n = 1'b0;
      @(negedge clk_sys);
      reset_n = 1'b1;
      chk("mid_flags", int'({vm.pe, vm.hs, vm.vs, vm.hb, vm.vb}),
          int'(5'b01100));
      chk("mid_hcnt", int'(vm.hcnt), 0);
      chk("mid_vcnt", int'(vm.vcnt), 0);
      wait_for(0, 1'b1, 100, n);
      chk("mid_first_pe", n, 4);

      // zero porches: hb and hs move together, no gap pixels
      @(negedge clk_sys);
      rs_n = 1'b0;
      @(negedge clk_sys);
      rs_n = 1'b1;
      n = 0;
      while (vsm.hb !== 1'b1 && n < 500) begin
         @(negedge clk_sys);
         n++;
      end
      chk("zp_hb_rise", n, 33);
      chk("zp_hs_with_hb", int'(vsm.hs), 0);
      chk("zp_hcnt", int'(vsm.hcnt), 8);
      n = 0;
      while (vsm.hs !== 1'b1 && n < 500) begin
         @(negedge clk_sys);
         n++;
      end
      chk("zp_hs_low", n, 16);
      chk("zp_hb_fall", int'(vsm.hb), 0);
      chk("zp_hcnt_wrap", int'(vsm.hcnt), 0);

      // one frame on the small raster: 13 lines, vs low 3 lines
      n = 0;
      while (vsm.vs !== 1'b0 && n < 2000) begin
         @(negedge clk_sys);
         n++;
      end
      chk("vs_fall_hs", int'(vsm.hs), 0);
      chk("vs_fall_line", int'(vsm.vcnt), 8);
      falls = 0;
      rise_falls = -1;
      rise_at = -1;
      rise_ok = 1'b0;
      vb_err = 0;
      vc_err = 0;
      wrap = 1'b0;
      done = 1'b0;
      prev_vc = int'(vsm.vcnt);
      ph = vsm.hs;
      pv = vsm.vs;
      for (int k = 0; k < 2000 && !done; k++) begin
         @(negedge clk_sys);
         if (ph && !vsm.hs) falls++;
         if (vsm.vb !== (vsm.vcnt >= 4'd6)) vb_err++;
         if (int'(vsm.vcnt) != prev_vc) begin
            expv = (prev_vc == 12) ? 0 : prev_vc + 1;
            if (int'(vsm.vcnt) != expv) vc_err++;
            if (prev_vc == 12 && vsm.vcnt == 4'd0) wrap = 1'b1;
            prev_vc = int'(vsm.vcnt);
         end
         if (!pv && vsm.vs) begin
            rise_falls = falls;
            rise_at = k + 1;
            rise_ok = ph && !vsm.hs;
         end
         if (pv && !vsm.vs) done = 1'b1;
         ph = vsm.hs;
         pv = vsm.vs;
      end
      chk("frame_done", int'(done), 1);
      chk("hs_per_frame", falls, 13);
      chk("vs_low_lines", rise_falls, 3);
      chk("vs_low_clks", rise_at, 144);
      chk("vs_rise_on_hs", int'(rise_ok), 1);
      chk("vb_track", vb_err, 0);
      chk("vcnt_seq", vc_err, 0);
      chk("vcnt_wrap", int'(wrap), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
